sddr_wrlvl_cal: RTL and testbench
=================================

Name: sddr_wrlvl_cal

Overview:
- Parametrised write-leveling calibration sequencer for the DDR3 PHY.
- Generalises the single combined delay-increment condition to LANES independent byte lanes. Each lane gets its own tap counter, edge detection, lock flag and failure flag.
- Sits between the controller and the PHY. It drives the controller's write-level and DQS-pulse requests and the per-lane IDELAY CE/LD controls, and consumes the registered per-lane DQ feedback bit.

Parameters:
- LANES, 2, number of byte lanes (DATA_BITS/8)
- TAP_BITS, 5, IDELAY tap counter width; max tap = 2**TAP_BITS-1
- SETTLE_CYCLES, 16, idle cycles after a tap change before pulsing (>=1)
- SAMPLES, 4, DQS pulses per tap; a lane reads 1 only if all samples are 1 (>=1)
- FB_LATENCY, 4, cycles from dqs_pulse_o to valid dq_fb_i (>=1)

Ports:
- in_ddr_clock_i  in  1  DDR clock; all logic on its rising edge
- in_phy_reset_i  in  1  synchronous active-high reset
- start_i  in  1  begin calibration; honoured only in IDLE, DONE or FAIL
- dq_fb_i  in  LANES  registered DQ feedback bit per lane (OR of the lane's DQ bits, registered by the PHY)
- write_level_o  out  1  drives ctl_write_level; high from LOAD through DECIDE/STEP
- dqs_pulse_o  out  1  one-cycle request for a single DQS strobe (to ctl_out_dqs)
- delay_ld_o  out  1  one-cycle load of tap 0 into all lane IDELAYs
- delay_ce_o  out  LANES  one-cycle increment per lane; INC is tied 1 externally
- tap_o  out  LANES*TAP_BITS  current tap per lane, lane 0 in the LSBs
- busy_o  out  1  calibration in progress
- done_o  out  1  level; high after every lane has locked
- fail_o  out  1  level; high if any lane failed
- lane_fail_o  out  LANES  per-lane failure flag

Behaviour:
- Reset (takes effect on the clock edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Taps, lock, fail, seen_zero, accumulators and counters are cleared.
  - Reset mid-run aborts immediately. The physical IDELAY is not reset; the next start reissues LD.
- FSM states: IDLE, LOAD, SETTLE, PULSE, WAIT, DECIDE, STEP, DONE, FAIL.
- IDLE/DONE/FAIL + start_i -> LOAD.
  - Clears taps, lock, lane_fail, seen_zero, done_o and fail_o.
  - start_i in any other state is ignored.
- LOAD (1 cycle):
  - delay_ld_o=1, write_level_o=1, busy_o=1.
  - Sample count is cleared and all accumulators are set to 1.
  - -> SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles -> PULSE.
- PULSE (1 cycle): dqs_pulse_o=1 -> WAIT.
- WAIT: FB_LATENCY cycles.
  - On the last WAIT cycle, acc[l] &= dq_fb_i[l] and the sample count increments.
  - Count < SAMPLES -> PULSE; otherwise -> DECIDE.
- DECIDE (1 cycle), for each lane not locked and not failed:
  - acc=1 and seen_zero=1 -> lock (0->1 edge at the current tap).
  - Otherwise, if acc=0, set seen_zero.
  - Otherwise, if tap = max -> lane_fail. This also covers a lane that reads 1 at tap 0 and never sees 0.
- After DECIDE:
  - All lanes locked or failed -> DONE if no failures, else FAIL.
  - Otherwise -> STEP.
- STEP (1 cycle):
  - delay_ce_o[l]=1 and tap[l]++ for each lane still unlocked and not failed.
  - Sample count and accumulators are reset.
  - -> SETTLE.
- Taps:
  - Never wrap; a lane at max tap is failed in DECIDE before any increment.
  - A locked lane's tap_o holds its value.
- DONE: busy_o=0, write_level_o=0, done_o=1 (held until the next start or reset).
- FAIL: busy_o=0, write_level_o=0, fail_o=1, lane_fail_o valid.
- Per-tap duration: SETTLE_CYCLES + SAMPLES*(1+FB_LATENCY) + 2 cycles.
- Outputs are registered (Moore); no combinational path from inputs to outputs.

Test Plan (unless noted: LANES=2, TAP_BITS=5, SETTLE_CYCLES=2, SAMPLES=2, FB_LATENCY=1; per-tap cycle = 8):
- Reset mid-SETTLE: assert in_phy_reset_i one cycle -> next cycle all outputs 0, tap_o=0, FSM idle; start_i afterwards produces delay_ld_o.
- Nominal, modelled feedback lane0 = (tap>=5), lane1 = (tap>=9):
  - delay_ld_o pulses once and dqs_pulse_o fires 2x per tap.
  - Final tap_o lane0=5, lane1=9; done_o=1, fail_o=0.
  - Lane0 receives exactly 5 CE pulses and lane1 exactly 9.
- Feedback always 1 on lane1: at tap 31, lane_fail_o=2'b10, fail_o=1, lane0 locks at its edge, no CE issued beyond tap 31.
- Glitchy sample: lane0 fb reads 1,0 at tap 3 then 1,1 at tap 4 -> tap 3 is treated as 0, lane0 locks at 4.
- start_i pulsed while busy_o=1 -> ignored, no extra delay_ld_o; start_i in DONE restarts with taps cleared to 0.
- Timing check: first dqs_pulse_o occurs exactly 1+SETTLE_CYCLES cycles after the LOAD cycle; consecutive tap CE pulses are exactly 8 cycles apart.

Source files
------------

// File: rtl/sddr_wrlvl_cal.sv
// Write-leveling calibration sequencer for LANES independent byte lanes.
// Each lane sweeps its IDELAY tap upward from 0. At every tap the sequencer issues
// SAMPLES DQS strobes and ANDs the registered DQ feedback. A lane locks on the first
// tap that reads 1 after some earlier tap has read 0. A lane fails if it reaches the
// maximum tap without locking.
//
// Ports:
//   in_ddr_clock_i  DDR clock, rising edge
//   in_phy_reset_i  synchronous active-high reset
//   start_i         begin calibration (honoured in IDLE/DONE/FAIL only)
//   dq_fb_i         per-lane registered DQ feedback bit
//   write_level_o   write-level request to controller
//   dqs_pulse_o     one-cycle DQS strobe request
//   delay_ld_o      one-cycle IDELAY load (tap 0), all lanes
//   delay_ce_o      one-cycle IDELAY increment, per lane
//   tap_o           current tap per lane, lane 0 in the LSBs
//   busy_o          calibration in progress
//   done_o          all lanes locked (level)
//   fail_o          at least one lane failed (level)
//   lane_fail_o     per-lane failure flag
module sddr_wrlvl_cal #(
  parameter int unsigned LANES         = 2,
  parameter int unsigned TAP_BITS      = 5,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLES       = 4,
  parameter int unsigned FB_LATENCY    = 4
) (
  input  logic                      in_ddr_clock_i,
  input  logic                      in_phy_reset_i,
  input  logic                      start_i,
  input  logic [LANES-1:0]          dq_fb_i,
  output logic                      write_level_o,
  output logic                      dqs_pulse_o,
  output logic                      delay_ld_o,
  output logic [LANES-1:0]          delay_ce_o,
  output logic [LANES*TAP_BITS-1:0] tap_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic [LANES-1:0]          lane_fail_o
);

  localparam int unsigned CntMax = (SETTLE_CYCLES > FB_LATENCY) ? SETTLE_CYCLES : FB_LATENCY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned SmpW   = $clog2(SAMPLES + 1);
  localparam logic [TAP_BITS-1:0] TapMax = {TAP_BITS{1'b1}};

  typedef enum logic [3:0] {
    StIdle, StLoad, StSettle, StPulse, StWait, StDecide, StStep, StDone, StFail
  } state_e;

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [SmpW-1:0]                 smp_q, smp_d;
  logic [LANES-1:0]                acc_q, acc_d;
  logic [LANES-1:0]                seen_q, seen_d;
  logic [LANES-1:0]                lock_q, lock_d;
  logic [LANES-1:0]                lfail_q, lfail_d;
  logic [LANES-1:0][TAP_BITS-1:0]  tap_q, tap_d;

  // Output registers, loaded from the next state so outputs line up with the state.
  logic             wl_q, pulse_q, ld_q, busy_q, done_q, failo_q;
  logic [LANES-1:0] ce_q, ce_d;
  logic             run_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    acc_d   = acc_q;
    seen_d  = seen_q;
    lock_d  = lock_q;
    lfail_d = lfail_q;
    tap_d   = tap_q;
    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start_i) begin
          state_d = StLoad;
          tap_d   = '0;
          lock_d  = '0;
          lfail_d = '0;
          seen_d  = '0;
        end
      end
      StLoad: begin
        smp_d   = '0;
        acc_d   = '1;
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPulse: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CntW'(FB_LATENCY - 1)) begin
          cnt_d   = '0;
          acc_d   = acc_q & dq_fb_i;
          smp_d   = smp_q + SmpW'(1);
          state_d = (smp_d < SmpW'(SAMPLES)) ? StPulse : StDecide;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecide: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (!lock_q[l] && !lfail_q[l]) begin
            if (acc_q[l] && seen_q[l]) begin
              lock_d[l] = 1'b1;
            end else begin
              if (!acc_q[l]) seen_d[l] = 1'b1;
              // Failing at max tap regardless of reading keeps the tap from wrapping.
              if (tap_q[l] == TapMax) lfail_d[l] = 1'b1;
            end
          end
        end
        if (&(lock_d | lfail_d)) begin
          state_d = (|lfail_d) ? StFail : StDone;
        end else begin
          state_d = StStep;
        end
      end
      StStep: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (!lock_q[l] && !lfail_q[l]) tap_d[l] = tap_q[l] + TAP_BITS'(1);
        end
        smp_d   = '0;
        acc_d   = '1;
        cnt_d   = '0;
        state_d = StSettle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run_d = (state_d == StLoad) || (state_d == StSettle) || (state_d == StPulse) ||
            (state_d == StWait) || (state_d == StDecide) || (state_d == StStep);
    // Lock/fail decided in DECIDE apply to the CE issued on the following STEP.
    ce_d  = (state_d == StStep) ? ~(lock_d | lfail_d) : '0;
  end

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_phy_reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      smp_q   <= '0;
      acc_q   <= '0;
      seen_q  <= '0;
      lock_q  <= '0;
      lfail_q <= '0;
      tap_q   <= '0;
      wl_q    <= 1'b0;
      pulse_q <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      failo_q <= 1'b0;
      ce_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
      seen_q  <= seen_d;
      lock_q  <= lock_d;
      lfail_q <= lfail_d;
      tap_q   <= tap_d;
      wl_q    <= run_d;
      pulse_q <= (state_d == StPulse);
      ld_q    <= (state_d == StLoad);
      busy_q  <= run_d;
      done_q  <= (state_d == StDone);
      failo_q <= (state_d == StFail);
      ce_q    <= ce_d;
    end
  end

  assign write_level_o = wl_q;
  assign dqs_pulse_o   = pulse_q;
  assign delay_ld_o    = ld_q;
  assign delay_ce_o    = ce_q;
  assign tap_o         = tap_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fail_o        = failo_q;
  assign lane_fail_o   = lfail_q;

endmodule

// File: tb/tb_sddr_wrlvl_cal.sv
// Directed bench for sddr_wrlvl_cal with LANES=2, TAP_BITS=5, SETTLE_CYCLES=2,
// SAMPLES=2, FB_LATENCY=1 (8 cycles per tap). Feedback is modelled from tap_o.
module tb_sddr_wrlvl_cal;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dq_fb = 2'b00;
  logic       write_level, dqs_pulse, delay_ld, busy, done, fail;
  logic [1:0] delay_ce, lane_fail;
  logic [9:0] tap;

  sddr_wrlvl_cal #(
    .LANES(2), .TAP_BITS(5), .SETTLE_CYCLES(2), .SAMPLES(2), .FB_LATENCY(1)
  ) dut (
    .in_ddr_clock_i(clk),
    .in_phy_reset_i(rst),
    .start_i       (start),
    .dq_fb_i       (dq_fb),
    .write_level_o (write_level),
    .dqs_pulse_o   (dqs_pulse),
    .delay_ld_o    (delay_ld),
    .delay_ce_o    (delay_ce),
    .tap_o         (tap),
    .busy_o        (busy),
    .done_o        (done),
    .fail_o        (fail),
    .lane_fail_o   (lane_fail)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // 0: lane0 edge at 5, lane1 at 9; 1: lane0 edge at 6, lane1 stuck 1;
  // 2: lane0 reads 1,0 at tap 3 and 1 from tap 4, lane1 edge at 2.
  int mode = 0;

  // Monitor state, written only by the monitor process.
  int cyc = 0, n_ld = 0, n_pulse = 0, n_ce0 = 0, n_ce1 = 0;
  int ld_cyc = 0, first_pulse_cyc = -1, ce1_prev = 0, ce1_last = 0;
  bit par = 1'b0;

  always @(negedge clk) begin
    logic [4:0] t0, t1;
    t0 = tap[4:0];
    t1 = tap[9:5];
    cyc++;
    if (delay_ld) begin
      n_ld++;
      par = 1'b0;
      ld_cyc = cyc;
      first_pulse_cyc = -1;
    end
    if (dqs_pulse) begin
      case (mode)
        0: dq_fb = {t1 >= 5'd9, t0 >= 5'd5};
        1: dq_fb = {1'b1, t0 >= 5'd6};
        default: dq_fb = {t1 >= 5'd2, (t0 >= 5'd4) || (t0 == 5'd3 && !par)};
      endcase
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
      n_pulse++;
      par = ~par;
    end
    if (delay_ce[0]) n_ce0++;
    if (delay_ce[1]) begin
      n_ce1++;
      ce1_prev = ce1_last;
      ce1_last = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (!(done || fail) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("run_terminates", 64'(done || fail), 64'd1);
  endtask

  int ld0, pl0, c00, c10;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {busy, write_level, dqs_pulse, delay_ld, delay_ce, done, fail,
                             lane_fail, tap}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-SETTLE aborts the run.
    pulse_start();
    check_eq("ld_on_start", 64'(delay_ld), 64'd1);
    @(negedge clk);
    check_eq("busy_in_settle", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_outputs", {busy, write_level, dqs_pulse, delay_ld, delay_ce, done, fail,
                                 lane_fail, tap}, '0);
    repeat (4) @(negedge clk);
    check_eq("idle_after_rst", 64'({busy, dqs_pulse}), 64'd0);

    // Nominal run with a start pulse while busy.
    mode = 0;
    ld0 = n_ld; pl0 = n_pulse; c00 = n_ce0; c10 = n_ce1;
    pulse_start();
    check_eq("ld_after_rst", 64'(delay_ld), 64'd1);
    repeat (20) @(negedge clk);
    check_eq("busy_mid_run", 64'(busy), 64'd1);
    pulse_start();
    wait_end(2000);
    check_eq("nom_first_pulse_gap", 64'(first_pulse_cyc - ld_cyc), 64'd3);
    check_eq("nom_ld_count", 64'(n_ld - ld0), 64'd1);
    check_eq("nom_pulse_count", 64'(n_pulse - pl0), 64'd20);
    check_eq("nom_tap0", 64'(tap[4:0]), 64'd5);
    check_eq("nom_tap1", 64'(tap[9:5]), 64'd9);
    check_eq("nom_ce0", 64'(n_ce0 - c00), 64'd5);
    check_eq("nom_ce1", 64'(n_ce1 - c10), 64'd9);
    check_eq("nom_ce_spacing", 64'(ce1_last - ce1_prev), 64'd8);
    check_eq("nom_flags", 64'({done, fail, lane_fail, busy, write_level}), 64'b10_00_0_0);

    // Restart from DONE in the glitchy-sample scenario.
    mode = 2;
    pulse_start();
    check_eq("restart_ld", 64'(delay_ld), 64'd1);
    check_eq("restart_taps_clear", 64'(tap), 64'd0);
    check_eq("restart_done_clear", 64'(done), 64'd0);
    wait_end(2000);
    check_eq("glitch_tap0", 64'(tap[4:0]), 64'd4);
    check_eq("glitch_tap1", 64'(tap[9:5]), 64'd2);
    check_eq("glitch_done", 64'({done, fail}), 64'b10);

    // Lane1 feedback stuck at 1: it sweeps to the top tap and fails.
    mode = 1;
    c00 = n_ce0; c10 = n_ce1;
    pulse_start();
    wait_end(4000);
    check_eq("stuck_flags", 64'({done, fail}), 64'b01);
    check_eq("stuck_lane_fail", 64'(lane_fail), 64'b10);
    check_eq("stuck_tap0", 64'(tap[4:0]), 64'd6);
    check_eq("stuck_tap1", 64'(tap[9:5]), 64'd31);
    check_eq("stuck_ce0", 64'(n_ce0 - c00), 64'd6);
    check_eq("stuck_ce1", 64'(n_ce1 - c10), 64'd31);
    repeat (20) @(negedge clk);
    check_eq("stuck_hold", 64'({fail, busy, tap[9:5]}), 64'({1'b1, 1'b0, 5'd31}));
    check_eq("stuck_no_extra_ce", 64'(n_ce1 - c10), 64'd31);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
